// File: rtl/shift_pipe_checker.sv
// Response monitor for a 2-stage shift pipeline (a -> b -> c).
// It rebuilds the expected b/c history from a_in, compares it with the observed b/c values,
// then counts and flags any mismatches.
// Optional feature: define COLLAPSE_DETECT_EN to add the sticky `collapsed` output.
module shift_pipe_checker #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned ERR_W   = 8,
  parameter int unsigned MAX_ERR = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_obs,
  input  logic [WIDTH-1:0] c_obs,
  output logic             mis_b,
  output logic             mis_c,
  output logic [ERR_W-1:0] err_cnt,
  output logic             locked,
  output logic             halted
`ifdef COLLAPSE_DETECT_EN
  ,
  output logic             collapsed
`endif
);

  localparam logic [ERR_W:0] MaxErr = (ERR_W+1)'(MAX_ERR);

  typedef enum logic [1:0] {StIdle, StFill, StCheck, StHalt} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] h1_q, h2_q;
  logic             v1_q, v2_q;
  logic             mis_b_q, mis_c_q, halted_q;
  logic [ERR_W-1:0] err_cnt_q;

  logic             mis_b_d, mis_c_d, any_mis, halt_hit;
  logic [ERR_W:0]   cnt_inc;
  logic [ERR_W-1:0] cnt_sat;

  // Compare observed values against the history registers held before this edge.
  always_comb begin
    // Case inequality makes X/Z on the observed inputs count as a mismatch.
    mis_b_d  = v1_q && (b_obs !== h1_q);
    mis_c_d  = v2_q && (c_obs !== h2_q);
    any_mis  = mis_b_d | mis_c_d;
    cnt_inc  = {1'b0, err_cnt_q} + (ERR_W+1)'(any_mis);
    cnt_sat  = (&err_cnt_q) ? err_cnt_q : cnt_inc[ERR_W-1:0];
    halt_hit = any_mis && (cnt_inc >= MaxErr);
  end

`ifdef COLLAPSE_DETECT_EN
  logic collapsed_q;

  // Sticky flag: c carried the a of the previous edge, so the pipeline lost a stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      collapsed_q <= 1'b0;
    end else if (state_q != StHalt && en && mis_c_d && (c_obs === h1_q) && (h1_q != h2_q)) begin
      collapsed_q <= 1'b1;
    end
  end

  assign collapsed = collapsed_q;
`endif

  // Run the FSM, history shift, mismatch pulses and saturating error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      h1_q      <= '0;
      h2_q      <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      mis_b_q   <= 1'b0;
      mis_c_q   <= 1'b0;
      err_cnt_q <= '0;
      halted_q  <= 1'b0;
    end else if (state_q == StHalt) begin
      // Everything frozen; only the mismatch pulses decay.
      mis_b_q <= 1'b0;
      mis_c_q <= 1'b0;
    end else if (!en) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      mis_b_q <= 1'b0;
      mis_c_q <= 1'b0;
      state_q <= StIdle;
    end else begin
      h2_q    <= h1_q;
      h1_q    <= a_in;
      v2_q    <= v1_q;
      v1_q    <= 1'b1;
      mis_b_q <= mis_b_d;
      mis_c_q <= mis_c_d;
      if (any_mis) begin
        err_cnt_q <= cnt_sat;
      end
      if (halt_hit) begin
        state_q  <= StHalt;
        halted_q <= 1'b1;
      end else begin
        case (state_q)
          StIdle:  state_q <= StFill;
          // v2 becomes valid at this edge, so both compares are live from the next one.
          StFill:  if (v1_q) state_q <= StCheck;
          default: state_q <= state_q;
        endcase
      end
    end
  end

  assign mis_b   = mis_b_q;
  assign mis_c   = mis_c_q;
  assign err_cnt = err_cnt_q;
  assign halted  = halted_q;
  assign locked  = (state_q == StCheck);

endmodule
